twenty_bit_shift_add_multiplier: RTL and testbench

Sequential 20x20 -> 40-bit unsigned multiplier built around one instance of twenty_bit_adder, the existing 20-bit ripple adder. Each cycle the block drives the adder with the running partial-product high half and the multiplicand, then consumes the adder's sum and carry-out to form the next partial product. It sits between operand issue and writeback in the datapath, with a start/busy/done handshake toward the control unit. Fixed latency of 20 iterations; no operand-dependent early exit.

---
 rtl/twenty_bit_shift_add_multiplier.sv | 134 +++++++++++++
 tb/tb_twenty_bit_shift_add_multiplier.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/twenty_bit_shift_add_multiplier.sv
// Sequential 20x20 -> 40-bit unsigned shift-add multiplier.
// One 20-bit ripple adder is reused every cycle; 20 iterations per product.

// 20-bit ripple-carry adder, carry-in tied low.
module twenty_bit_adder (
  input  logic [19:0] i0,
  input  logic [19:0] i1,
  output logic [19:0] s,
  output logic        cout
);

  // Bit-serial carry ripple from LSB to MSB.
  always_comb begin
    logic carry;
    carry = 1'b0;
    s     = '0;
    for (int i = 0; i < 20; i++) begin
      s[i]  = i0[i] ^ i1[i] ^ carry;
      carry = (i0[i] & i1[i]) | (carry & (i0[i] ^ i1[i]));
    end
    cout = carry;
  end

endmodule

module twenty_bit_shift_add_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [19:0] a,
  input  logic [19:0] b,
  output logic [39:0] product,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e      state_q, state_d;
  logic [19:0] mcand_q;
  logic [19:0] hi_q, hi_d;
  logic [19:0] lo_q, lo_d;
  logic [4:0]  count_q;
  logic [39:0] product_q;

  logic [19:0] sum;
  logic        cout;
  logic        accept;
  logic        last_iter;

  twenty_bit_adder u_adder (
    .i0   (hi_q),
    .i1   (mcand_q),
    .s    (sum),
    .cout (cout)
  );

  // A start is honoured whenever no iteration is in flight.
  assign accept    = start && (state_q != StRun);
  assign last_iter = (state_q == StRun) && (count_q == 5'd19);

  // Conditional add, then shift {carry, partial hi, lo} right by one.
  always_comb begin
    logic        c;
    logic [19:0] t;
    if (lo_q[0]) begin
      c = cout;
      t = sum;
    end else begin
      c = 1'b0;
      t = hi_q;
    end
    hi_d = {c, t[19:1]};
    lo_d = {t[0], lo_q[19:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun:   if (count_q == 5'd19) state_d = StDone;
      StDone:  state_d = start ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      StIdle:  ;
      StRun:   busy = 1'b1;
      StDone:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath registers: operand capture, iteration, product latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else if (accept) begin
      mcand_q <= a;
      hi_q    <= '0;
      lo_q    <= b;
      count_q <= '0;
    end else if (state_q == StRun) begin
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      count_q <= count_q + 5'd1;
      if (last_iter) begin
        product_q <= {hi_d, lo_d};
      end
    end
  end

  assign product = product_q;

endmodule

// File: tb/tb_twenty_bit_shift_add_multiplier.sv
// Directed bench for the shift-add multiplier with an expected-result queue.
module tb_twenty_bit_shift_add_multiplier;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] a;
  logic [19:0] b;
  logic [39:0] product;
  logic        busy;
  logic        done;

  int checks;
  int failures;
  logic [39:0] exp_q[$];

  twenty_bit_shift_add_multiplier dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one accepted request; operands are scrambled after the edge.
  task automatic issue(input logic [19:0] x, input logic [19:0] y);
    a = x;
    b = y;
    start = 1'b1;
    exp_q.push_back(40'(x) * 40'(y));
    step();
    start = 1'b0;
    a = 20'($urandom);
    b = 20'($urandom);
    chk("busy_after_accept", 40'(busy), 40'd1);
    chk("done_after_accept", 40'(done), 40'd0);
  endtask

  // Wait for done with a bounded budget; n0 = edges already elapsed since accept.
  task automatic wait_done(input string tag, input int n0);
    int n;
    n = n0;
    while (n < 30 && !done) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 40'(n), 40'd20);
    chk({tag, "_busy_at_done"}, 40'(busy), 40'd0);
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 40'd1, 40'd0);
    end else begin
      chk({tag, "_product"}, product, exp_q.pop_front());
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    chk("reset_busy", 40'(busy), 40'd0);
    chk("reset_done", 40'(done), 40'd0);
    chk("reset_product", product, 40'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Zero operands.
    issue(20'd0, 20'd0);
    wait_done("zero", 0);
    step();
    chk("done_single_cycle", 40'(done), 40'd0);

    // Small operands.
    issue(20'd1, 20'd1);
    wait_done("one", 0);
    step();
    issue(20'd111, 20'd222);
    wait_done("mid", 0);
    step();
    issue(20'd1000, 20'd1000);
    wait_done("thousand", 0);
    step();

    // Carry stress.
    issue(20'hFFFFF, 20'hFFFFF);
    wait_done("max_max", 0);
    chk("max_max_const", product, 40'hFFFFE00001);
    step();
    issue(20'hFFFFF, 20'd1);
    wait_done("max_one", 0);
    step();

    // Start during RUN must be ignored.
    issue(20'd3, 20'd5);
    repeat (4) step();
    a = 20'd7;
    b = 20'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("ignored_start", 5);
    chk("ignored_start_const", product, 40'd15);

    // Hold with start low.
    for (int i = 0; i < 50; i++) begin
      step();
      chk("hold_product", product, 40'd15);
      chk("hold_busy", 40'(busy), 40'd0);
      chk("hold_done", 40'(done), 40'd0);
    end

    // Back-to-back accept in the done cycle.
    issue(20'd3, 20'd5);
    wait_done("b2b_first", 0);
    issue(20'd2, 20'd9);
    wait_done("b2b_second", 0);
    chk("b2b_second_const", product, 40'd18);
    step();

    // Asynchronous reset mid-run.
    issue(20'd100, 20'd100);
    repeat (9) step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", 40'(busy), 40'd0);
    chk("async_done", 40'(done), 40'd0);
    chk("async_product", product, 40'd0);
    exp_q.delete();
    step();
    #2;
    rst_n = 1'b1;
    step();
    chk("post_reset_busy", 40'(busy), 40'd0);
    chk("post_reset_done", 40'(done), 40'd0);
    issue(20'd6, 20'd7);
    wait_done("after_reset", 0);
    chk("after_reset_const", product, 40'd42);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
